accumulator_result_streamer: RTL

- Downstream of the systolic array top level. Captures the N x N accumulator results produced during the accumulator drain phase into a local buffer.
- Once the drain completes, serializes the buffer row-major onto a single valid/ready stream for writeback/DMA.
- Flags any cell that never reported valid, so matrix-multiply result integrity is checkable.

---
 rtl/accumulator_result_streamer_if.sv | 30 +++
 rtl/accumulator_result_streamer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/accumulator_result_streamer_if.sv
// Result stream bus between the accumulator streamer and its consumer
// (writeback / DMA).
//   out_data_o  : streamed result word
//   out_valid_o : out_data_o valid
//   out_ready_i : consumer ready; a word moves on valid & ready
//   out_last_o  : final word of the matrix, cell (N-1,N-1)
//   out_row_o   : row index of the current word
//   out_col_o   : column index of the current word
// Signal suffixes are from the streamer's point of view.
interface accumulator_result_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 3
);
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  out_last_o;
    logic [IDX_W-1:0]      out_row_o;
    logic [IDX_W-1:0]      out_col_o;

    modport master (
        output out_data_o, out_valid_o, out_last_o, out_row_o, out_col_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o, out_valid_o, out_last_o, out_row_o, out_col_o,
        output out_ready_i
    );
endinterface

// File: rtl/accumulator_result_streamer.sv
// Captures the N x N accumulator results the systolic array reports during
// its drain phase, then streams them row-major over a valid/ready bus.
// Cells that never reported valid are streamed as 0 and raise missing_o.
//   clk_i, rstn_i      : clock, asynchronous active-low reset
//   start_i            : arm a new capture (IDLE or CAPTURE)
//   results_i          : per-cell accumulator results
//   results_valid_i    : per-cell valid, same cycle as results_i
//   drain_complete_i   : drain-complete level; its rising edge ends capture
//   out_if             : result stream (master side)
//   busy_o             : capturing or streaming
//   done_o             : one-cycle pulse after the last word is accepted
//   missing_o          : sticky, a cell was never captured this run
module accumulator_result_streamer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic                                   start_i,
    input  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]    results_i,
    input  logic [0:N-1][0:N-1]                    results_valid_i,
    input  logic                                   drain_complete_i,
    accumulator_result_streamer_if.master          out_if,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   missing_o
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_STREAM, S_DONE} state_e;

    state_e                                state_q, state_d;
    logic [0:N-1][0:N-1][DATA_WIDTH-1:0]   buf_q, buf_d;
    logic [0:N-1][0:N-1]                   cap_q, cap_d;
    logic                                  missing_q, missing_d;
    logic                                  drain_prev_q, drain_prev_d;
    logic [IDX_W-1:0]                      row_q, row_d;
    logic [IDX_W-1:0]                      col_q, col_d;

    logic streaming;
    logic last;

    assign streaming = (state_q == S_STREAM);
    assign last      = streaming && (row_q == IDX_W'(N-1)) && (col_q == IDX_W'(N-1));

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cap_d        = cap_q;
        missing_d    = missing_q;
        row_d        = row_q;
        col_d        = col_q;
        drain_prev_d = drain_complete_i;
        case (state_q)
            S_IDLE: begin
                // Buffer is left as-is; the captured bits alone decide
                // whether stale data can reach the stream.
                if (start_i) begin
                    cap_d     = '0;
                    missing_d = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // A restart clears first so valids in the same cycle still land.
                if (start_i) begin
                    cap_d     = '0;
                    missing_d = 1'b0;
                end
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (results_valid_i[i][j]) begin
                            buf_d[i][j] = results_i[i][j];
                            cap_d[i][j] = 1'b1;
                        end
                    end
                end
                // Missing is judged after this cycle's valids are folded in.
                if (!start_i && drain_complete_i && !drain_prev_q) begin
                    missing_d = ~&cap_d;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_if.out_ready_i) begin
                    if (last) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_DONE;
                    end else if (col_q == IDX_W'(N-1)) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cap_q        <= '0;
            missing_q    <= 1'b0;
            drain_prev_q <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cap_q        <= cap_d;
            missing_q    <= missing_d;
            drain_prev_q <= drain_prev_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    // Uncaptured cells read as 0; the data bus is quiet outside STREAM.
    assign out_if.out_data_o  = (streaming && cap_q[row_q][col_q]) ? buf_q[row_q][col_q]
                                                                   : '0;
    assign out_if.out_valid_o = streaming;
    assign out_if.out_last_o  = last;
    assign out_if.out_row_o   = row_q;
    assign out_if.out_col_o   = col_q;
    assign busy_o             = (state_q == S_CAPTURE) || streaming;
    assign done_o             = (state_q == S_DONE);
    assign missing_o          = missing_q;

endmodule
